banyan_scheduler: RTL
=====================

// Module: banyan_scheduler
// PURPOSE
//  Cycle-by-cycle scheduler and output stage for the 4x4 banyan fabric (switch_4_by_4).
//  Accepts one 8-bit word per input port per cycle over valid/ready, tagged with a 2-bit destination.
//  Each cycle it grants a conflict-free subset of inputs (round-robin fairness), computes sel[3:0],
//  registers the granted words, routes them through switch_4_by_4 and registers the fabric outputs.
// PARAMETERS
//  DATA_W  8   word width; fixed at 8 to match switch_4_by_4 (any other value is an elaboration error)
//  CNT_W   16  width of blocked_cnt saturating counter
// PORTS
//  clk          in   1         single clock, all state on rising edge
//  rst          in   1         synchronous, active-high reset
//  en           in   1         1 = scheduling enabled; 0 = no grants issued
//  in_valid     in   4         bit i: port i holds a word
//  in_ready     out  4         bit i: port i granted this cycle (transfer = valid & ready)
//  in_dest      in   8         port i destination at [2i+1:2i]
//  in_data      in   32        port i word at [8i+7:8i]
//  out_valid    out  4         bit j: out_data lane j valid this cycle
//  out_data     out  32        lane j at [8j+7:8j]
//  out_src      out  8         lane j source port at [2j+1:2j]
//  blocked_cnt  out  CNT_W     count of cycles with en=1 and >=1 valid input not granted
// BEHAVIOUR
//  - Reset (rst=1 at edge): out_valid=0, out_data=0, out_src=0, rr_ptr=0, blocked_cnt=0, stage-1
//    regs and sel reg cleared. in_ready is forced 0 in any cycle with rst=1.
//  - Allocation (combinational, same cycle): for k=0..3, i=(rr_ptr+k)%4; grant i iff en & in_valid[i]
//    & stage-1 link (pair=i>>1, half=dest_i[1]) unused & output dest_i unused; mark both used.
//    Consequence: same-pair inputs with equal dest[1] block; equal destinations block. in_ready = grant.
//  - rr_ptr: if any grant, rr_ptr <= (first granted index in priority order)+1 mod 4; else hold.
//  - sel: sel[0] = g0 ? dest0[1] : g1 ? ~dest1[1] : 0; sel[1] = g2 ? dest2[1] : g3 ? ~dest3[1] : 0.
//    sel[2] (lanes 0/1): packet from pair0 with dest[1]=0 -> its dest[0]; else from pair1 with
//    dest[1]=0 -> ~its dest[0]; else 0. sel[3] identical for dest[1]=1 (lanes 2/3).
//  - Pipeline: edge A captures granted words (ungranted lanes zeroed), sel, per-dest valid/src tags;
//    switch_4_by_4 combinational; edge B registers outputs. Word granted in cycle t appears on
//    out_valid/out_data/out_src in cycle t+2, for exactly one cycle. Throughput up to 4 words/cycle.
//  - Output lanes never backpressure; out_data lanes with out_valid=0 are 0.
//  - blocked_cnt: +1 per cycle with en=1 and (in_valid & ~grant)!=0; saturates at 2^CNT_W-1.
//  - en=0: no grants, rr_ptr and blocked_cnt hold; in-flight words still drain to outputs.
//  - rst mid-operation: in-flight words in both stages discarded; no out_valid after reset edge.
//  - in_data/in_dest need only be stable while in_valid=1 and not yet granted.
// STRUCTURE
//  - banyan_pkg: N_PORTS=4, PORT_W=2, DATA_W=8, typedef port_idx_t [1:0], function route_sel
//    (grant vector, dests -> sel[3:0]) shared with the bench's reference model.
//  - Sub-module banyan_alloc: purely combinational greedy allocator (valid, dest, rr_ptr, en -> grant).
//  - Top instantiates banyan_alloc and existing switch_4_by_4; holds rr_ptr, pipeline regs, counter.
// TESTING
//  1 Full permutation: rr_ptr=0, dests {0,2,1,3}, data {A0,A1,A2,A3} -> in_ready=1111, sel=0000,
//    2 cycles later out_valid=1111, out_data lanes {A0,A2,A1,A3}, out_src {0,2,1,3}.
//  2 Identity blocking: dests {0,1,2,3} all valid, rr_ptr=0 -> grant 0101, rr_ptr->1, blocked_cnt=1;
//    next cycle (in1,in3 held) grant 1010; outputs lanes 0,2 then lanes 1,3.
//  3 Hot spot: all 4 valid, dest=3, held -> grants in0,in1,in2,in3 on 4 consecutive cycles;
//    out_valid=1000 each cycle, out_src[7:6]=0,1,2,3; blocked_cnt=3.
//  4 en=0 with all valid -> in_ready=0000, no out_valid, blocked_cnt unchanged; en=1 resumes at rr_ptr.
//  5 Reset mid-flight: grant in0 (dest 1) at t, rst=1 at t+1 -> out_valid=0 at t+2, all outputs 0.
//  6 Saturation, CNT_W=4: 20 blocked cycles -> blocked_cnt=15 and holds; rst -> 0.

Source files
------------

// File: rtl/banyan_pkg.sv
// Shared types and routing helper for the 4x4 banyan scheduler and its reference model.
package banyan_pkg;

    localparam int N_PORTS = 4;
    localparam int PORT_W  = 2;
    localparam int DATA_W  = 8;

    typedef logic [PORT_W-1:0] port_idx_t;

    typedef struct packed {
        logic      vld;
        port_idx_t src;
    } lane_tag_t;

    // Stage-1 sel follows the granted packet's half; stage-2 sel follows its low dest bit.
    function automatic logic [3:0] route_sel(input logic [N_PORTS-1:0] grant,
                                             input logic [N_PORTS*PORT_W-1:0] dests);
        logic [3:0] s;
        port_idx_t  d [N_PORTS];
        for (int i = 0; i < N_PORTS; i++) begin
            d[i] = dests[PORT_W*i +: PORT_W];
        end
        s = '0;
        s[0] = grant[0] ? d[0][1] : (grant[1] ? ~d[1][1] : 1'b0);
        s[1] = grant[2] ? d[2][1] : (grant[3] ? ~d[3][1] : 1'b0);
        for (int h = 0; h < 2; h++) begin
            if      (grant[0] && d[0][1] == h[0]) s[2+h] = d[0][0];
            else if (grant[1] && d[1][1] == h[0]) s[2+h] = d[1][0];
            else if (grant[2] && d[2][1] == h[0]) s[2+h] = ~d[2][0];
            else if (grant[3] && d[3][1] == h[0]) s[2+h] = ~d[3][0];
        end
        return s;
    endfunction

endpackage

// File: rtl/banyan_alloc.sv
// Greedy round-robin allocator: grants inputs whose stage-1 link and output are both free.
// Combinational, zero latency; an ungranted input simply sees in_ready low (backpressure).
module banyan_alloc
    import banyan_pkg::*;
(
    input  logic                           en,
    input  logic      [N_PORTS-1:0]        in_valid,
    input  port_idx_t [N_PORTS-1:0]        dest,
    input  port_idx_t                      rr_ptr,
    output logic      [N_PORTS-1:0]        grant,
    output port_idx_t                      first_idx,
    output logic                           any_grant
);

    logic [3:0] link_used;
    logic [3:0] out_used;
    port_idx_t  idx;
    logic [1:0] link;

    always_comb begin
        grant     = '0;
        first_idx = '0;
        any_grant = 1'b0;
        link_used = '0;
        out_used  = '0;
        idx       = '0;
        link      = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            idx  = rr_ptr + 2'(k);
            link = {idx[1], dest[idx][1]};
            if (en && in_valid[idx] && !link_used[link] && !out_used[dest[idx]]) begin
                grant[idx]           = 1'b1;
                link_used[link]      = 1'b1;
                out_used[dest[idx]]  = 1'b1;
                if (!any_grant) begin
                    first_idx = idx;
                end
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_4_by_4.sv
// Two-stage 4x4 banyan fabric of 2x2 crossbar elements; purely combinational.
// sel[1:0] steer input pairs onto half links, sel[3:2] steer halves onto output lanes.
module switch_4_by_4 (
    input  logic [3:0]  sel,
    input  logic [31:0] in_data,
    output logic [31:0] out_data
);

    logic [7:0] l00, l01, l10, l11;

    assign l00 = sel[0] ? in_data[15:8]  : in_data[7:0];
    assign l01 = sel[0] ? in_data[7:0]   : in_data[15:8];
    assign l10 = sel[1] ? in_data[31:24] : in_data[23:16];
    assign l11 = sel[1] ? in_data[23:16] : in_data[31:24];

    assign out_data[7:0]   = sel[2] ? l10 : l00;
    assign out_data[15:8]  = sel[2] ? l00 : l10;
    assign out_data[23:16] = sel[3] ? l11 : l01;
    assign out_data[31:24] = sel[3] ? l01 : l11;

endmodule

// File: rtl/banyan_scheduler.sv
// Scheduler + output stage for the 4x4 banyan: grant, route, register; grant-to-output latency 2.
// Inputs are backpressured via in_ready (grant); output lanes never stall.
module banyan_scheduler
    import banyan_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [3:0]            in_valid,
    output logic [3:0]            in_ready,
    input  logic [7:0]            in_dest,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic [3:0]            out_valid,
    output logic [4*DATA_W-1:0]   out_data,
    output logic [7:0]            out_src,
    output logic [CNT_W-1:0]      blocked_cnt
);

    if (DATA_W != banyan_pkg::DATA_W) begin : g_bad_width
        $error("banyan_scheduler: DATA_W must be 8 to match switch_4_by_4");
    end

    port_idx_t [N_PORTS-1:0]             dest;
    logic      [N_PORTS-1:0]             grant;
    port_idx_t                           first_idx;
    logic                                any_grant;
    logic      [4*DATA_W-1:0]            sw_out;

    port_idx_t                           rr_ptr_q, rr_ptr_d;
    logic      [4*DATA_W-1:0]            s1_data_q, s1_data_d;
    logic      [3:0]                     sel_q, sel_d;
    lane_tag_t [N_PORTS-1:0]             s1_tag_q, s1_tag_d;
    logic      [3:0]                     out_valid_q, out_valid_d;
    logic      [4*DATA_W-1:0]            out_data_q, out_data_d;
    logic      [7:0]                     out_src_q, out_src_d;
    logic      [CNT_W-1:0]               blocked_q, blocked_d;

    assign dest = in_dest;

    banyan_alloc u_alloc (
        .en        (en & ~rst),
        .in_valid  (in_valid),
        .dest      (dest),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .first_idx (first_idx),
        .any_grant (any_grant)
    );

    switch_4_by_4 u_switch (
        .sel      (sel_q),
        .in_data  (s1_data_q),
        .out_data (sw_out)
    );

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        s1_data_d   = '0;
        s1_tag_d    = '0;
        sel_d       = route_sel(grant, in_dest);
        out_valid_d = '0;
        out_data_d  = '0;
        out_src_d   = '0;
        blocked_d   = blocked_q;

        if (any_grant) begin
            rr_ptr_d = first_idx + 2'd1;
        end

        // Tags are indexed by destination so they line up with fabric output lanes.
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant[i]) begin
                s1_data_d[DATA_W*i +: DATA_W] = in_data[DATA_W*i +: DATA_W];
                s1_tag_d[dest[i]].vld         = 1'b1;
                s1_tag_d[dest[i]].src         = 2'(i);
            end
        end

        for (int j = 0; j < N_PORTS; j++) begin
            out_valid_d[j]            = s1_tag_q[j].vld;
            out_src_d[PORT_W*j +: PORT_W] = s1_tag_q[j].src;
            if (s1_tag_q[j].vld) begin
                out_data_d[DATA_W*j +: DATA_W] = sw_out[DATA_W*j +: DATA_W];
            end
        end

        if (en && (in_valid & ~grant) != 4'b0 && blocked_q != {CNT_W{1'b1}}) begin
            blocked_d = blocked_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            s1_data_q   <= '0;
            sel_q       <= '0;
            s1_tag_q    <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            blocked_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            s1_data_q   <= s1_data_d;
            sel_q       <= sel_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            blocked_q   <= blocked_d;
        end
    end

    assign in_ready    = grant;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_src     = out_src_q;
    assign blocked_cnt = blocked_q;

endmodule
